// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 32-character, two-line text buffer for an LCD controller.
// The block writes characters at a cursor, clears the buffer, and returns a
// registered read port to the downstream LCD refresh engine.
// Optional build macro: LCD_TEXT_BUFFER_SCROLL_EN. When it is defined, a write
// at the last cell scrolls line 2 up into line 1 and blanks line 2. Without it,
// the cursor wraps to 0.
module lcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       cmd_clear,
  input  logic       cmd_home,
  output logic       busy,
  output logic [4:0] cursor,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       dirty,
  input  logic       refresh_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1
`ifdef LCD_TEXT_BUFFER_SCROLL_EN
    , S_SCROLL = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  cursor_q, cursor_d;
  logic        dirty_q, dirty_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  mem_q [32];
  logic [7:0]  mem_d [32];

  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        set_dirty;

  // Next-state logic: command arbitration in IDLE, sequenced sweeps otherwise.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cursor_d  = cursor_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = FILL_CHAR;
    set_dirty = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_clear) begin
          state_d = S_CLEAR;
          idx_d   = 5'd0;
        end else if (cmd_home) begin
          cursor_d = 5'd0;
        end else if (wr_en) begin
          mem_we    = 1'b1;
          mem_waddr = cursor_q;
          mem_wdata = wr_data;
          cursor_d  = cursor_q + 5'd1;
          set_dirty = 1'b1;
`ifdef LCD_TEXT_BUFFER_SCROLL_EN
          if (cursor_q == 5'd31) begin
            state_d = S_SCROLL;
            idx_d   = 5'd0;
          end
`endif
        end
      end
      S_CLEAR: begin
        mem_we = 1'b1;
        idx_d  = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d   = S_IDLE;
          cursor_d  = 5'd0;
          set_dirty = 1'b1;
        end
      end
`ifdef LCD_TEXT_BUFFER_SCROLL_EN
      S_SCROLL: begin
        // First half copies line 2 into line 1, second half blanks line 2.
        mem_we = 1'b1;
        if (!idx_q[4]) mem_wdata = mem_q[{1'b1, idx_q[3:0]}];
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d   = S_IDLE;
          cursor_d  = 5'd16;
          set_dirty = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_CLEAR;
        idx_d   = 5'd0;
      end
    endcase
    // A new change beats an acknowledge landing on the same edge.
    if (set_dirty)        dirty_d = 1'b1;
    else if (refresh_ack) dirty_d = 1'b0;
    else                  dirty_d = dirty_q;
    rd_data_d = mem_q[rd_addr];
  end

  // Storage update; writes are held off while reset is asserted.
  always_comb begin
    mem_d = mem_q;
    if (mem_we && rst) mem_d[mem_waddr] = mem_wdata;
  end

  // Control registers; reset parks the FSM at the start of a clear sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      idx_q     <= 5'd0;
      cursor_q  <= 5'd0;
      dirty_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cursor_q  <= cursor_d;
      dirty_q   <= dirty_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Character storage is not reset; the post-reset clear initialises it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy    = (state_q != S_IDLE);
  assign cursor  = cursor_q;
  assign rd_data = rd_data_q;
  assign dirty   = dirty_q;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed testbench for lcd_text_buffer. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_lcd_text_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       cmd_clear = 1'b0;
  logic       cmd_home = 1'b0;
  logic       busy;
  logic [4:0] cursor;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       dirty;
  logic       refresh_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_text_buffer #(.FILL_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .cmd_clear(cmd_clear), .cmd_home(cmd_home), .busy(busy),
    .cursor(cursor), .rd_addr(rd_addr), .rd_data(rd_data),
    .dirty(dirty), .refresh_ack(refresh_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Registered read: address applied now, data valid one edge later.
  task automatic read_mem(input logic [4:0] a, output logic [7:0] d);
    rd_addr = a;
    step();
    d = rd_data;
  endtask

  // Count cycles until busy falls, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic write_char(input logic [7:0] c);
    wr_en = 1'b1; wr_data = c;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] d;
    rst = 1'b0;
    repeat (5) step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b exp 1", busy); end
    n_checks++; if (cursor !== 5'd0) begin n_fail++; $display("FAIL rst_cursor got %0d exp 0", cursor); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd_data got %h exp 00", rd_data); end
    n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL rst_dirty got %b exp 0", dirty); end
    rst = 1'b1;
    wait_idle(n);
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL rst_busy_len got %0d exp 32", n); end
    n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL rst_dirty_done got %b exp 1", dirty); end
    n_checks++; if (cursor !== 5'd0) begin n_fail++; $display("FAIL rst_cursor_done got %0d exp 0", cursor); end
    for (int i = 0; i < 32; i++) begin
      read_mem(5'(i), d);
      n_checks++; if (d !== 8'h20) begin n_fail++; $display("FAIL rst_mem[%0d] got %h exp 20", i, d); end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    write_char(8'h48);
    write_char(8'h49);
    n_checks++; if (cursor !== 5'd2) begin n_fail++; $display("FAIL wr_cursor got %0d exp 2", cursor); end
    n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL wr_dirty got %b exp 1", dirty); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy got %b exp 0", busy); end
    read_mem(5'd1, d);
    n_checks++; if (d !== 8'h49) begin n_fail++; $display("FAIL wr_rd1 got %h exp 49", d); end
    read_mem(5'd0, d);
    n_checks++; if (d !== 8'h48) begin n_fail++; $display("FAIL wr_rd0 got %h exp 48", d); end
  endtask

  task automatic test_dirty();
    refresh_ack = 1'b1;
    step();
    refresh_ack = 1'b0;
    n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL dirty_ack got %b exp 0", dirty); end
    refresh_ack = 1'b1; wr_en = 1'b1; wr_data = 8'h4A;
    step();
    refresh_ack = 1'b0; wr_en = 1'b0;
    n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL dirty_ack_wr got %b exp 1", dirty); end
    n_checks++; if (cursor !== 5'd3) begin n_fail++; $display("FAIL dirty_cursor got %0d exp 3", cursor); end
    refresh_ack = 1'b1;
    step();
    refresh_ack = 1'b0;
  endtask

  task automatic test_priority_busy();
    int n;
    logic [7:0] d;
    cmd_clear = 1'b1; wr_en = 1'b1; wr_data = 8'h41;
    step();
    cmd_clear = 1'b0; wr_en = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pri_busy got %b exp 1", busy); end
    n = 0;
    while (busy && n < 100) begin
      wr_en = (n < 5); wr_data = 8'h55; cmd_home = (n == 7);
      step();
      n++;
    end
    wr_en = 1'b0; cmd_home = 1'b0;
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL pri_busy_len got %0d exp 32", n); end
    n_checks++; if (cursor !== 5'd0) begin n_fail++; $display("FAIL pri_cursor got %0d exp 0", cursor); end
    n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL pri_dirty got %b exp 1", dirty); end
    read_mem(5'd0, d);
    n_checks++; if (d !== 8'h20) begin n_fail++; $display("FAIL pri_mem0 got %h exp 20", d); end
    read_mem(5'd1, d);
    n_checks++; if (d !== 8'h20) begin n_fail++; $display("FAIL pri_mem1 got %h exp 20", d); end
  endtask

  task automatic test_home();
    logic [7:0] d;
    write_char(8'h41);
    write_char(8'h42);
    cmd_home = 1'b1; wr_en = 1'b1; wr_data = 8'h5A;
    step();
    cmd_home = 1'b0; wr_en = 1'b0;
    n_checks++; if (cursor !== 5'd0) begin n_fail++; $display("FAIL home_cursor got %0d exp 0", cursor); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL home_busy got %b exp 0", busy); end
    read_mem(5'd0, d);
    n_checks++; if (d !== 8'h41) begin n_fail++; $display("FAIL home_mem0 got %h exp 41", d); end
    read_mem(5'd2, d);
    n_checks++; if (d !== 8'h20) begin n_fail++; $display("FAIL home_mem2 got %h exp 20", d); end
  endtask

  task automatic fill_32();
    for (int i = 0; i < 32; i++) write_char(8'h30 + 8'(i % 10));
  endtask

`ifndef LCD_TEXT_BUFFER_SCROLL_EN
  task automatic test_wrap();
    logic [7:0] d;
    logic saw_busy;
    saw_busy = 1'b0;
    for (int i = 0; i < 32; i++) begin
      write_char(8'h30 + 8'(i % 10));
      if (busy) saw_busy = 1'b1;
    end
    n_checks++; if (cursor !== 5'd0) begin n_fail++; $display("FAIL wrap_cursor got %0d exp 0", cursor); end
    n_checks++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy got %b exp 0", saw_busy); end
    read_mem(5'd31, d);
    n_checks++; if (d !== 8'h31) begin n_fail++; $display("FAIL wrap_mem31 got %h exp 31", d); end
    read_mem(5'd0, d);
    n_checks++; if (d !== 8'h30) begin n_fail++; $display("FAIL wrap_mem0 got %h exp 30", d); end
    read_mem(5'd15, d);
    n_checks++; if (d !== 8'h35) begin n_fail++; $display("FAIL wrap_mem15 got %h exp 35", d); end
  endtask
`else
  task automatic test_scroll();
    int n;
    logic [7:0] d;
    fill_32();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL scr_busy got %b exp 1", busy); end
    n = 0;
    while (busy && n < 100) begin
      cmd_home = (n == 3); cmd_clear = (n == 20);
      step();
      n++;
    end
    cmd_home = 1'b0; cmd_clear = 1'b0;
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL scr_busy_len got %0d exp 32", n); end
    n_checks++; if (cursor !== 5'd16) begin n_fail++; $display("FAIL scr_cursor got %0d exp 16", cursor); end
    n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL scr_dirty got %b exp 1", dirty); end
    for (int i = 0; i < 16; i++) begin
      read_mem(5'(i), d);
      n_checks++;
      if (d !== 8'h30 + 8'((16 + i) % 10)) begin
        n_fail++; $display("FAIL scr_mem[%0d] got %h exp %h", i, d, 8'h30 + 8'((16 + i) % 10));
      end
    end
    for (int i = 16; i < 32; i++) begin
      read_mem(5'(i), d);
      n_checks++; if (d !== 8'h20) begin n_fail++; $display("FAIL scr_mem[%0d] got %h exp 20", i, d); end
    end
  endtask

  task automatic test_scroll_reset();
    int n;
    logic [7:0] d;
    cmd_home = 1'b1; step(); cmd_home = 1'b0;
    fill_32();
    repeat (10) step();
    rst = 1'b0;
    repeat (2) step();
    n_checks++; if (cursor !== 5'd0) begin n_fail++; $display("FAIL scrrst_cursor got %0d exp 0", cursor); end
    rst = 1'b1;
    wait_idle(n);
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL scrrst_busy_len got %0d exp 32", n); end
    for (int i = 0; i < 32; i += 5) begin
      read_mem(5'(i), d);
      n_checks++; if (d !== 8'h20) begin n_fail++; $display("FAIL scrrst_mem[%0d] got %h exp 20", i, d); end
    end
  endtask
`endif

  initial begin
    step();
    test_reset();
    test_write_read();
    test_dirty();
    test_priority_busy();
    test_home();
    cmd_home = 1'b1; step(); cmd_home = 1'b0;
`ifndef LCD_TEXT_BUFFER_SCROLL_EN
    test_wrap();
`else
    test_scroll();
    test_scroll_reset();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
